// File: rtl/axi_h266enc_v2_0.sv
// Register front end for the matrix solver: loads equations over AXI slave, starts a solve,
// then writes the result words out as one INCR burst. Define AXI_H266ENC_IRQ_EN to add irq_o.
module axi_h266enc_v2_0 #(
  parameter int DATA_BITS    = 64,
  parameter int ROWS         = 6,
  parameter int COLS         = 7,
  parameter int RESULT_WORDS = 6
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [31:0]                       s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [DATA_BITS-1:0]              s_axi_wdata,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [31:0]                       s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [DATA_BITS-1:0]              s_axi_rdata,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [31:0]                       m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_BITS-1:0]              m_axi_wdata,
  output logic [DATA_BITS/8-1:0]            m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic                              comp_init_o,
  output logic                              affine_param6_o,
  output logic [ROWS*COLS*DATA_BITS-1:0]    comp_data_o,
  input  logic                              comp_done_i,
  input  logic [RESULT_WORDS*DATA_BITS-1:0] comp_data_i
`ifdef AXI_H266ENC_IRQ_EN
  ,
  output logic                              irq_o
`endif
);

  localparam int            ENTRIES   = ROWS * COLS;
  localparam int            KW        = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
  localparam logic [KW-1:0] LAST_BEAT = KW'(RESULT_WORDS - 1);
  localparam logic [6:0]    ENTRY_LIM = 7'(ENTRIES);
  localparam logic [9:0]    OFF_BASE  = 10'h000;
  localparam logic [9:0]    OFF_CTRL  = 10'h008;
  localparam logic [9:0]    OFF_STAT  = 10'h010;

  typedef enum logic [2:0] {IDLE, SOLVE, ADDR, DATA, RESP} state_t;
  state_t state, state_nx;

  logic [DATA_BITS-1:0] matrix [ENTRIES];
  logic [DATA_BITS-1:0] result [RESULT_WORDS];
  logic [31:0]          base, xfer_base;
  logic                 param6, irq_ena, done, berr;
  logic [KW-1:0]        beat;
  logic [DATA_BITS-1:0] rd_val;

  logic [9:0] wr_off, rd_off;
  logic [5:0] wr_idx, rd_idx;
  logic       wr_en, rd_en, wr_is_mat, rd_is_mat, start_go, set_done, unused_addr;

  assign wr_off      = s_axi_awaddr[9:0];
  assign rd_off      = s_axi_araddr[9:0];
  assign wr_idx      = wr_off[8:3];
  assign rd_idx      = rd_off[8:3];
  assign wr_is_mat   = wr_off[9] && (wr_off[2:0] == 3'b000) && ({1'b0, wr_idx} < ENTRY_LIM);
  assign rd_is_mat   = rd_off[9] && (rd_off[2:0] == 3'b000) && ({1'b0, rd_idx} < ENTRY_LIM);
  assign unused_addr = ^{s_axi_awaddr[31:10], s_axi_araddr[31:10]};

  // Ready is gated by reset so no handshake can complete while the block is held in reset.
  assign wr_en = s_axi_aresetn && s_axi_awvalid && s_axi_wvalid && (!s_axi_bvalid || s_axi_bready);
  assign rd_en = s_axi_aresetn && s_axi_arvalid && (!s_axi_rvalid || s_axi_rready);
  assign s_axi_awready = wr_en;
  assign s_axi_wready  = wr_en;
  assign s_axi_arready = rd_en;

  assign start_go = wr_en && (wr_off == OFF_CTRL) && s_axi_wdata[0] && (state == IDLE);
  assign set_done = (state == RESP) && m_axi_bvalid;

  assign m_axi_awvalid = (state == ADDR);
  assign m_axi_awaddr  = xfer_base;
  assign m_axi_awlen   = 8'(RESULT_WORDS - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_BITS / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = (state == DATA);
  assign m_axi_wdata   = result[beat];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state == DATA) && (beat == LAST_BEAT);
  assign m_axi_bready  = (state == RESP);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_flat
    assign comp_data_o[g*DATA_BITS +: DATA_BITS] = matrix[g];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_go) state_nx = SOLVE;
      SOLVE:   if (comp_done_i) state_nx = ADDR;
      ADDR:    if (m_axi_awready) state_nx = DATA;
      DATA:    if (m_axi_wready && (beat == LAST_BEAT)) state_nx = RESP;
      RESP:    if (m_axi_bvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      base         <= '0;
      param6       <= 1'b0;
      s_axi_bvalid <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) matrix[i] <= '0;
    end else begin
      if (wr_en) s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (wr_en && (wr_off == OFF_BASE)) base <= {s_axi_wdata[31:3], 3'b000};
      if (wr_en && (wr_off == OFF_CTRL)) param6 <= s_axi_wdata[1];
      if (wr_en && wr_is_mat) matrix[wr_idx] <= s_axi_wdata;
    end
  end

  // Transfer parameters are snapshotted at START so later register writes leave the burst alone.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      comp_init_o     <= 1'b0;
      affine_param6_o <= 1'b0;
      xfer_base       <= '0;
      beat            <= '0;
      done            <= 1'b0;
      berr            <= 1'b0;
      for (int j = 0; j < RESULT_WORDS; j++) result[j] <= '0;
    end else begin
      comp_init_o <= start_go;
      if (start_go) begin
        xfer_base       <= base;
        affine_param6_o <= s_axi_wdata[1];
        beat            <= '0;
        done            <= 1'b0;
        berr            <= 1'b0;
      end else begin
        if (wr_en && (wr_off == OFF_STAT) && s_axi_wdata[1]) done <= 1'b0;
        if (wr_en && (wr_off == OFF_STAT) && s_axi_wdata[2]) berr <= 1'b0;
        if (set_done) begin
          done <= 1'b1;
          if (m_axi_bresp != 2'b00) berr <= 1'b1;
        end
      end
      if ((state == SOLVE) && comp_done_i)
        for (int j = 0; j < RESULT_WORDS; j++) result[j] <= comp_data_i[j*DATA_BITS +: DATA_BITS];
      if ((state == DATA) && m_axi_wready && (beat != LAST_BEAT)) beat <= beat + 1'b1;
    end
  end

`ifdef AXI_H266ENC_IRQ_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      irq_ena <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      if (wr_en && (wr_off == OFF_CTRL)) irq_ena <= s_axi_wdata[2];
      irq_o <= done && irq_ena;
    end
  end
`else
  assign irq_ena = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    if (rd_is_mat) rd_val = matrix[rd_idx];
    else begin
      case (rd_off)
        OFF_BASE: rd_val[31:0] = base;
        OFF_CTRL: rd_val[2:0]  = {irq_ena, param6, 1'b0};
        OFF_STAT: rd_val[2:0]  = {berr, done, (state != IDLE)};
        default:  rd_val       = '0;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rdata  <= '0;
      s_axi_rvalid <= 1'b0;
    end else if (rd_en) begin
      s_axi_rdata  <= rd_val;
      s_axi_rvalid <= 1'b1;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_h266enc_v2_0.sv
// Randomized bench for axi_h266enc_v2_0: register map model, solver stub and AXI write slave.
module tb_axi_h266enc_v2_0;
  localparam int DB = 64, ROWS = 6, COLS = 7, RW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [DB-1:0] s_axi_wdata, s_axi_rdata, m_axi_wdata;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst, m_axi_bresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready;
  logic [DB/8-1:0] m_axi_wstrb;
  logic comp_init_o, affine_param6_o, comp_done_i;
  logic [ROWS*COLS*DB-1:0] comp_data_o;
  logic [RW*DB-1:0] comp_data_i;
`ifdef AXI_H266ENC_IRQ_EN
  logic irq_o;
`endif

  axi_h266enc_v2_0 #(.DATA_BITS(DB), .ROWS(ROWS), .COLS(COLS), .RESULT_WORDS(RW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .comp_init_o(comp_init_o), .affine_param6_o(affine_param6_o), .comp_data_o(comp_data_o),
    .comp_done_i(comp_done_i), .comp_data_i(comp_data_i)
`ifdef AXI_H266ENC_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  int vectors = 0;
  int errors = 0;
  int init_count = 0;
  logic [DB-1:0] words [RW];
  logic [DB-1:0] mat_model [ROWS][COLS];

  always @(posedge clk) if (comp_init_o === 1'b1) init_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wvalid = 0; s_axi_bready = 1;
    s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 1;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 2'b00; m_axi_bvalid = 0;
    comp_done_i = 0; comp_data_i = '0;
  endtask

  task automatic axi_write(input logic [9:0] off, input logic [DB-1:0] data);
    int n;
    @(negedge clk);
    s_axi_awaddr = {22'h0, off}; s_axi_wdata = data;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    #1;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      vectors++; errors++;
      $display("FAIL wr_timeout off=%h awready=%b required 1", off, s_axi_awready);
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [9:0] off, output logic [DB-1:0] data);
    int n;
    @(negedge clk);
    s_axi_araddr = {22'h0, off}; s_axi_arvalid = 1'b1;
    n = 0;
    #1;
    while (!s_axi_arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      vectors++; errors++;
      $display("FAIL rd_timeout off=%h arready=%b required 1", off, s_axi_arready);
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    vectors++;
    if (s_axi_rvalid !== 1'b1) begin
      errors++; $display("FAIL rvalid off=%h got %b required 1", off, s_axi_rvalid);
    end
    data = s_axi_rdata;
  endtask

  // One START-to-BRESP transaction, acting as solver and AXI write slave.
  task automatic run_transfer(input logic [31:0] exp_base, input logic param6, input logic [1:0] resp,
                              input int long_stall_beat, input bit busy_pokes, input bit w1c_race,
                              input int abort_beat);
    int n, k, stall, c0;
    logic [DB-1:0] rd;
    logic [DB-1:0] exp_status;
    c0 = init_count;
    axi_write(10'h008, {62'h0, param6, 1'b1});
    n = 0;
    do begin @(negedge clk); n++; end while (comp_init_o !== 1'b1 && n < 10);
    vectors++;
    if (comp_init_o !== 1'b1) begin errors++; $display("FAIL init_pulse got %b required 1", comp_init_o); end
    vectors++;
    if (affine_param6_o !== param6) begin errors++; $display("FAIL param6_out got %b required %b", affine_param6_o, param6); end
    @(negedge clk);
    vectors++;
    if (comp_init_o !== 1'b0) begin errors++; $display("FAIL init_width got %b required 0", comp_init_o); end
    axi_read(10'h010, rd);
    vectors++;
    if (rd !== 64'h1) begin errors++; $display("FAIL status_solve got %h required 1", rd); end
    if (busy_pokes) begin
      axi_write(10'h008, {62'h0, ~param6, 1'b1});
      axi_write(10'h000, {32'h0, exp_base + 32'h100});
      @(negedge clk); @(negedge clk);
      vectors++;
      if (init_count !== c0 + 1) begin errors++; $display("FAIL busy_start init_pulses got %0d required %0d", init_count - c0, 1); end
      vectors++;
      if (affine_param6_o !== param6) begin errors++; $display("FAIL busy_param6 got %b required %b", affine_param6_o, param6); end
    end
    @(negedge clk);
    for (int j = 0; j < RW; j++) comp_data_i[j*DB +: DB] = words[j];
    comp_done_i = 1'b1;
    @(negedge clk);
    comp_done_i = 1'b0;
    comp_data_i = {RW{$urandom, $urandom}};
    n = 0;
    while (m_axi_awvalid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    stall = $urandom_range(0, 3);
    for (int d = 0; d <= stall; d++) begin
      vectors++;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== exp_base) begin
        errors++; $display("FAIL aw_addr valid=%b got %h required %h", m_axi_awvalid, m_axi_awaddr, exp_base);
      end
      vectors++;
      if ({m_axi_awlen, m_axi_awsize, m_axi_awburst} !== {8'd5, 3'd3, 2'b01}) begin
        errors++; $display("FAIL aw_ctl got len=%0d size=%0d burst=%0d required 5 3 1", m_axi_awlen, m_axi_awsize, m_axi_awburst);
      end
      if (d < stall) @(negedge clk);
    end
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    k = 0; n = 0;
    stall = (long_stall_beat == 0) ? 10 : $urandom_range(0, 2);
    while (k < RW && n < 200) begin
      if (k == abort_beat) break;
      vectors++;
      if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== words[k]) begin
        errors++; $display("FAIL beat%0d valid=%b got %h required %h", k, m_axi_wvalid, m_axi_wdata, words[k]);
      end
      vectors++;
      if (m_axi_wlast !== (k == RW - 1) || m_axi_wstrb !== 8'hFF) begin
        errors++; $display("FAIL beat%0d_ctl wlast=%b wstrb=%h required %b ff", k, m_axi_wlast, m_axi_wstrb, (k == RW - 1));
      end
      if (stall > 0) begin
        m_axi_wready = 1'b0; stall--;
      end else begin
        m_axi_wready = 1'b1; k++;
        stall = (long_stall_beat == k) ? 10 : $urandom_range(0, 2);
      end
      @(negedge clk); n++;
    end
    m_axi_wready = 1'b0;
    if (abort_beat >= 0) begin
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axi_bvalid, s_axi_rvalid, comp_init_o} !== 6'b0) begin
        errors++; $display("FAIL reset_outputs got %b required 000000",
          {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axi_bvalid, s_axi_rvalid, comp_init_o});
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        vectors++;
        if (m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL post_reset_wvalid got %b required 0", m_axi_wvalid); end
      end
      axi_read(10'h010, rd);
      vectors++;
      if (rd !== 64'h0) begin errors++; $display("FAIL post_reset_status got %h required 0", rd); end
      axi_read(10'h000, rd);
      vectors++;
      if (rd !== 64'h0) begin errors++; $display("FAIL post_reset_base got %h required 0", rd); end
      return;
    end
    vectors++;
    if (k != RW || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b1) begin
      errors++; $display("FAIL burst_end beats=%0d wvalid=%b bready=%b required %0d 0 1", k, m_axi_wvalid, m_axi_bready, RW);
    end
    stall = $urandom_range(0, 3);
    for (int d = 0; d < stall; d++) @(negedge clk);
    m_axi_bvalid = 1'b1; m_axi_bresp = resp;
    if (w1c_race) begin
      s_axi_awaddr = 32'h10; s_axi_wdata = 64'h2; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      #1;
      vectors++;
      if (s_axi_awready !== 1'b1) begin errors++; $display("FAIL race_accept got %b required 1", s_axi_awready); end
    end
    @(negedge clk);
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    vectors++;
    if (m_axi_bready !== 1'b0) begin errors++; $display("FAIL bready_idle got %b required 0", m_axi_bready); end
    exp_status = {61'h0, (resp != 2'b00), 1'b1, 1'b0};
    axi_read(10'h010, rd);
    vectors++;
    if (rd !== exp_status) begin errors++; $display("FAIL status_done got %h required %h", rd, exp_status); end
  endtask

  task automatic test_reset();
    logic [DB-1:0] rd;
    rst_n = 1'b0;
    idle_inputs();
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axi_awvalid,
         m_axi_wvalid, m_axi_bready, comp_init_o} !== 9'b0) begin
      errors++; $display("FAIL reset_ctl got %b required 0", {s_axi_awready, s_axi_wready, s_axi_arready,
        s_axi_bvalid, s_axi_rvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, comp_init_o});
    end
    vectors++;
    if (s_axi_rdata !== '0 || comp_data_o !== '0) begin
      errors++; $display("FAIL reset_data rdata=%h required 0", s_axi_rdata);
    end
    idle_inputs();
    rst_n = 1'b1;
    axi_read(10'h010, rd);
    vectors++;
    if (rd !== 64'h0) begin errors++; $display("FAIL reset_status got %h required 0", rd); end
    axi_read(10'h000, rd);
    vectors++;
    if (rd !== 64'h0) begin errors++; $display("FAIL reset_base got %h required 0", rd); end
  endtask

  task automatic test_regs();
    logic [DB-1:0] rd, v;
    logic [31:0] b;
    logic [9:0] off;
    logic [ROWS*COLS*DB-1:0] exp_flat;
    int i;
    axi_write(10'h000, 64'h1000_0007);
    axi_read(10'h000, rd);
    vectors++;
    if (rd !== 64'h1000_0000) begin errors++; $display("FAIL base_mask got %h required 10000000", rd); end
    b = $urandom;
    axi_write(10'h000, {$urandom, b});
    axi_read(10'h000, rd);
    vectors++;
    if (rd !== {32'h0, b[31:3], 3'b000}) begin errors++; $display("FAIL base_rand got %h required %h", rd, {b[31:3], 3'b000}); end
    for (int e = 0; e < ROWS * COLS; e++) begin
      v = {$urandom, $urandom};
      off = 10'(32'h200 + e * 8);
      axi_write(off, v);
      mat_model[e / COLS][e % COLS] = v;
    end
    axi_write(10'h348, 64'hA5);
    mat_model[41 / COLS][41 % COLS] = 64'hA5;
    axi_read(10'h348, rd);
    vectors++;
    if (rd !== 64'hA5) begin errors++; $display("FAIL matrix41 got %h required a5", rd); end
    axi_read(10'h350, rd);
    vectors++;
    if (rd !== 64'h0) begin errors++; $display("FAIL matrix_oob got %h required 0", rd); end
    for (int r = 0; r < 4; r++) begin
      i = $urandom_range(0, ROWS * COLS - 1);
      off = 10'(32'h200 + i * 8);
      axi_read(off, rd);
      vectors++;
      if (rd !== mat_model[i / COLS][i % COLS]) begin
        errors++; $display("FAIL matrix_rd%0d got %h required %h", i, rd, mat_model[i / COLS][i % COLS]);
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_flat[(r * COLS + c) * DB +: DB] = mat_model[r][c];
    vectors++;
    if (comp_data_o !== exp_flat) begin errors++; $display("FAIL comp_data_o row-major layout differs from model"); end
    axi_write(10'h008, 64'h2);
    axi_read(10'h008, rd);
    vectors++;
    if (rd !== 64'h2) begin errors++; $display("FAIL ctrl_param6 got %h required 2", rd); end
    axi_write(10'h008, 64'h4);
    axi_read(10'h008, rd);
    vectors++;
`ifdef AXI_H266ENC_IRQ_EN
    if (rd !== 64'h4) begin errors++; $display("FAIL ctrl_irqena got %h required 4", rd); end
`else
    if (rd !== 64'h0) begin errors++; $display("FAIL ctrl_irqena got %h required 0", rd); end
`endif
    axi_write(10'h008, 64'h0);
    axi_write(10'h018, {$urandom, $urandom});
    axi_read(10'h018, rd);
    vectors++;
    if (rd !== 64'h0) begin errors++; $display("FAIL unmapped_018 got %h required 0", rd); end
    axi_read(10'h204, rd);
    vectors++;
    if (rd !== 64'h0) begin errors++; $display("FAIL unaligned_204 got %h required 0", rd); end
    axi_read(10'h000, rd);
    vectors++;
    if (rd !== {32'h0, b[31:3], 3'b000}) begin errors++; $display("FAIL base_kept got %h required %h", rd, {b[31:3], 3'b000}); end
  endtask

  task automatic test_burst();
    for (int j = 0; j < RW; j++) words[j] = 64'(j + 1);
    axi_write(10'h000, 64'h1000_0000);
    run_transfer(32'h1000_0000, 1'b0, 2'b00, -1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall();
    logic [31:0] b;
    b = {$urandom_range(0, 32'h7FFF), 12'h000, 5'h0} & 32'hFFFF_F000;
    for (int j = 0; j < RW; j++) words[j] = {$urandom, $urandom};
    axi_write(10'h000, {32'h0, b});
    run_transfer(b, 1'b1, 2'b00, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_berr_busy();
    logic [DB-1:0] rd;
    for (int j = 0; j < RW; j++) words[j] = {$urandom, $urandom};
    axi_write(10'h000, 64'h2000_0000);
    run_transfer(32'h2000_0000, 1'b0, 2'b10, -1, 1'b1, 1'b0, -1);
    axi_read(10'h000, rd);
    vectors++;
    if (rd !== 64'h2000_0100) begin errors++; $display("FAIL busy_base_reg got %h required 20000100", rd); end
    axi_read(10'h008, rd);
    vectors++;
    if (rd !== 64'h2) begin errors++; $display("FAIL busy_ctrl_reg got %h required 2", rd); end
    axi_write(10'h010, 64'h6);
    axi_read(10'h010, rd);
    vectors++;
    if (rd !== 64'h0) begin errors++; $display("FAIL w1c_clear got %h required 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    for (int t = 0; t < 2; t++) begin
      b = $urandom & 32'hFFFF_F000;
      for (int j = 0; j < RW; j++) words[j] = {$urandom, $urandom};
      axi_write(10'h000, {32'h0, b});
      run_transfer(b, 1'($urandom_range(0, 1)), 2'b00, -1, 1'b0, (t == 1), -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int j = 0; j < RW; j++) words[j] = {$urandom, $urandom};
    axi_write(10'h000, 64'h3000_0000);
    run_transfer(32'h3000_0000, 1'b0, 2'b00, -1, 1'b0, 1'b0, 3);
    idle_inputs();
  endtask

`ifdef AXI_H266ENC_IRQ_EN
  task automatic test_irq();
    for (int j = 0; j < RW; j++) words[j] = {$urandom, $urandom};
    run_transfer(32'h0, 1'b0, 2'b00, -1, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);
    vectors++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_disabled got %b required 0", irq_o); end
    axi_write(10'h008, 64'h4);
    repeat (2) @(negedge clk);
    vectors++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_enabled got %b required 1", irq_o); end
    axi_write(10'h010, 64'h2);
    repeat (2) @(negedge clk);
    vectors++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b required 0", irq_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_burst();
    test_stall();
    test_berr_busy();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef AXI_H266ENC_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
